// File: rtl/aes_pkg.sv
// Shared AES datapath types, byte-order helpers and the ShiftRows FSM encoding.
// State bytes are column-major: byte k = 4*col+row lives at bits [127-8k -: 8].
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  row_t;
    typedef logic [127:0] state_t;

    localparam logic [7:0] AES_STD_SHIFT = 8'hE4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    // LSB position of the byte at (col,row) inside a state_t
    function automatic int unsigned byte_lsb(input int unsigned col, input int unsigned row);
        return 120 - 8 * (4 * col + row);
    endfunction

    // Row word is packed {col0, col1, col2, col3}, col0 in the top byte
    function automatic row_t get_row(input state_t s, input logic [1:0] r);
        row_t w;
        w = '0;
        for (int unsigned c = 0; c < 4; c++)
            w[24 - 8 * c +: 8] = s[byte_lsb(c, 32'(r)) +: 8];
        return w;
    endfunction

    function automatic state_t put_row(input state_t s, input logic [1:0] r, input row_t w);
        state_t t;
        t = s;
        for (int unsigned c = 0; c < 4; c++)
            t[byte_lsb(c, 32'(r)) +: 8] = w[24 - 8 * c +: 8];
        return t;
    endfunction

endpackage

// File: rtl/row_rotate.sv
// Combinational cyclic byte rotation of one state row; left by amt, or right when inv=1.
module row_rotate #(
    parameter int unsigned AMT_W = 2
) (
    input  logic [31:0]      row_in,
    input  logic [AMT_W-1:0] amt,
    input  logic             inv,
    output logic [31:0]      row_out
);

    logic [1:0] src;

    always_comb begin
        row_out = '0;
        src     = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            src = inv ? 2'(2'(c) - 2'(amt)) : 2'(2'(c) + 2'(amt));
            row_out[24 - 8 * c +: 8] = row_in[24 - 8 * 32'(src) +: 8];
        end
    end

endmodule

// File: rtl/dyn_shift_rows.sv
// Sequential ShiftRows with per-block row rotation amounts; one row per clock,
// valid/ready on both sides, result held in DONE until the consumer takes it.
module dyn_shift_rows
    import aes_pkg::*;
#(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned AMT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [127:0]          in_state,
    input  logic [AMT_W*ROWS-1:0] shift_ctrl,
    input  logic                  inv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_state,
    output logic                  busy
);

    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

    fsm_t                  state_q;
    state_t                st_q;
    logic [AMT_W*ROWS-1:0] ctrl_q;
    logic                  inv_q;
    logic [1:0]            row_cnt;
    row_t                  cur_row;
    row_t                  rot_row;
    logic [AMT_W-1:0]      amt;

    assign cur_row   = get_row(st_q, row_cnt);
    assign amt       = ctrl_q[AMT_W * row_cnt +: AMT_W];
    assign out_state = st_q;

    row_rotate #(.AMT_W(AMT_W)) u_rot (
        .row_in  (cur_row),
        .amt     (amt),
        .inv     (inv_q),
        .row_out (rot_row)
    );

    // Handshake flags are registered alongside the state, so in_ready stays
    // low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            st_q      <= '0;
            ctrl_q    <= '0;
            inv_q     <= 1'b0;
            row_cnt   <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        st_q     <= in_state;
                        ctrl_q   <= shift_ctrl;
                        inv_q    <= inv;
                        row_cnt  <= '0;
                        state_q  <= ST_SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    st_q    <= put_row(st_q, row_cnt, rot_row);
                    row_cnt <= row_cnt + 2'd1;
                    if (row_cnt == LAST_ROW) begin
                        state_q   <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q   <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dyn_shift_rows.sv
// Directed bench for dyn_shift_rows: a row/column array model predicts every
// result, and a negedge monitor compares each valid output against it.
module tb_dyn_shift_rows;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [7:0]   shift_ctrl;
    logic         inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] STD_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] STD_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] SEQ_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_FF  = 128'h0c0d0e0f000102030405060708090a0b;

    dyn_shift_rows #(.ROWS(4), .AMT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .shift_ctrl (shift_ctrl),
        .inv        (inv),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: view the state as a 4x4 grid and rotate each row by its amount
    function automatic logic [127:0] model(input logic [127:0] s, input logic [7:0] c, input logic iv);
        logic [7:0]   m[4][4];
        logic [127:0] r;
        int           n;
        int           src;
        r = '0;
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
                m[row][col] = s[127 - 8 * (4 * col + row) -: 8];
        for (int row = 0; row < 4; row++) begin
            n = int'(c >> (2 * row)) & 3;
            for (int col = 0; col < 4; col++) begin
                src = iv ? (col - n + 4) % 4 : (col + n) % 4;
                r[127 - 8 * (4 * col + row) -: 8] = m[row][src];
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got out_valid=1 expected no block outstanding");
            end else if (out_state !== exp_q[0]) begin
                errors++;
                $display("FAIL out_state: got %h expected %h", out_state, exp_q[0]);
            end
            if (out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
        end
    end

    task automatic send(input logic [127:0] s, input logic [7:0] c, input logic iv, output int acc_cyc);
        int n;
        n = 0;
        in_state = s; shift_ctrl = c; inv = iv; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
            in_valid = 1'b0;
            acc_cyc  = -1;
            return;
        end
        exp_q.push_back(model(s, c, iv));
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 1'b0; in_state = ~s; shift_ctrl = ~c; inv = ~iv;
    endtask

    task automatic wait_out(input int acc_cyc, input string name);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1 within 50 cycles", name);
        end else begin
            chk({name, "_latency"}, 128'(cyc - acc_cyc), 128'd4);
        end
    endtask

    initial begin
        int a0, a1;
        logic [127:0] held;
        rst_n = 1'b0; in_valid = 1'b0; in_state = '0; shift_ctrl = '0; inv = 1'b0; out_ready = 1'b1;

        chk("model_std", model(STD_IN, 8'hE4, 1'b0), STD_OUT);
        chk("model_inv", model(STD_OUT, 8'hE4, 1'b1), STD_IN);
        chk("model_ff",  model(SEQ_IN, 8'hFF, 1'b0), SEQ_FF);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy",      128'(busy),      128'd0);
        chk("rst_in_ready",  128'(in_ready),  128'd0);
        chk("rst_out_state", out_state,       128'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", 128'(in_ready), 128'd0);
        @(posedge clk); #1;
        chk("in_ready_after_release", 128'(in_ready), 128'd1);

        // standard AES ShiftRows
        send(STD_IN, 8'hE4, 1'b0, a0);
        chk("busy_after_accept",     128'(busy),     128'd1);
        chk("in_ready_after_accept", 128'(in_ready), 128'd0);
        wait_out(a0, "std");
        chk("std_value", out_state, STD_OUT);
        @(posedge clk); #1;
        chk("idle_out_valid", 128'(out_valid), 128'd0);
        chk("idle_in_ready",  128'(in_ready),  128'd1);
        chk("idle_busy",      128'(busy),      128'd0);

        send(STD_OUT, 8'hE4, 1'b1, a0);
        wait_out(a0, "inv");
        chk("inv_value", out_state, STD_IN);
        @(posedge clk); #1;

        send(128'h0123456789abcdeffedcba9876543210, 8'h00, 1'b0, a0);
        wait_out(a0, "ident");
        chk("ident_value", out_state, 128'h0123456789abcdeffedcba9876543210);
        @(posedge clk); #1;

        send(SEQ_IN, 8'hFF, 1'b0, a0);
        wait_out(a0, "ff");
        chk("ff_value", out_state, SEQ_FF);
        @(posedge clk); #1;

        // backpressure with a second block held pending on the input side
        out_ready = 1'b0;
        send(128'h3243f6a8885a308d313198a2e0370734, 8'h1B, 1'b1, a0);
        wait_out(a0, "bp");
        held = out_state;
        in_state = 128'hffeeddccbbaa99887766554433221100; shift_ctrl = 8'h6C; inv = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready",  128'(in_ready),  128'd0);
            chk("bp_stable",    out_state,       held);
        end
        out_ready = 1'b1;
        send(128'hffeeddccbbaa99887766554433221100, 8'h6C, 1'b0, a0);
        wait_out(a0, "pend");
        @(posedge clk); #1;

        // back-to-back: second accept exactly 6 cycles after the first
        send(128'h00112233445566778899aabbccddeeff, 8'h93, 1'b0, a0);
        send(128'h0f0e0d0c0b0a09080706050403020100, 8'h39, 1'b1, a1);
        chk("init_interval", 128'(a1 - a0), 128'd6);
        wait_out(a1, "b2b");
        @(posedge clk); #1;

        // reset two cycles into SHIFT
        send(128'hdeadbeefcafef00d0123456789abcdef, 8'hE4, 1'b0, a0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_busy",      128'(busy),      128'd0);
        chk("midrst_out_state", out_state,       128'd0);
        chk("midrst_in_ready",  128'(in_ready),  128'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send(STD_IN, 8'hE4, 1'b0, a0);
        wait_out(a0, "post_rst");
        chk("post_rst_value", out_state, STD_OUT);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
